// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative multiply/divide unit owning the HI/LO registers.
// One product or quotient bit is produced per cycle; signs are stripped on
// entry and reapplied in a single fix-up cycle before HI/LO are written.
module ex_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Clrn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t state, state_next;

  logic [5:0]         cnt;
  logic               div_q;
  logic               sign_a;
  logic               sign_b;
  logic               b_zero;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;

  logic               accept;
  logic               mt_wr;
  logic               op_signed;
  logic               op_div;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  assign accept    = start & ~flush;
  assign mt_wr     = wr_hi | wr_lo;
  assign op_div    = op[1];
  assign op_signed = ~op[0];
  assign busy      = (state != IDLE);

  // Operand magnitudes; the most negative value maps to itself as unsigned.
  always_comb begin
    mag_a = (op_signed && a[WIDTH-1]) ? ('0 - a) : a;
    mag_b = (op_signed && b[WIDTH-1]) ? ('0 - b) : b;
  end

  // One iteration step and the sign fix-up of the finished result.
  // acc holds {product-high, multiplier} for multiply and
  // {partial remainder, dividend/quotient} for divide.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
    prod_fix  = (sign_a ^ sign_b) ? ('0 - acc) : acc;
    quo_fix   = (sign_a ^ sign_b) ? ('0 - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    rem_fix   = sign_a ? ('0 - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
    fix_hi    = div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    fix_lo    = div_q ? quo_fix : prod_fix[WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) state <= IDLE;
    else       state <= state_next;
  end

  // Next state: a start restarts from any state, an MT write aborts.
  always_comb begin
    state_next = state;
    if (accept) begin
      state_next = RUN;
    end else if (mt_wr) begin
      state_next = IDLE;
    end else begin
      case (state)
        RUN:     if (cnt == 6'd1) state_next = FIX;
        FIX:     state_next = IDLE;
        default: state_next = state;
      endcase
    end
  end

  // Datapath, counter and HI/LO; start beats MT write, MT write beats fix-up.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      cnt    <= '0;
      div_q  <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      b_zero <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
      done   <= 1'b0;
      dz     <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      dz   <= 1'b0;
      if (accept) begin
        div_q  <= op_div;
        sign_a <= op_signed & a[WIDTH-1];
        sign_b <= op_signed & b[WIDTH-1];
        b_zero <= (b == '0);
        opnd   <= op_div ? mag_b : mag_a;
        acc    <= op_div ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
        cnt    <= 6'(WIDTH);
      end else if (mt_wr) begin
        if (wr_hi) hi <= wdata;
        if (wr_lo) lo <= wdata;
      end else if (state == RUN) begin
        cnt <= cnt - 6'd1;
        acc <= div_q ? div_next : mul_next;
      end else if (state == FIX) begin
        hi   <= fix_hi;
        lo   <= fix_lo;
        done <= 1'b1;
        dz   <= div_q & b_zero;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: directed operations with hand-computed HI/LO/dz and
// completion cycle queued at issue, checked by an independent done monitor.
module tb_ex_muldiv;

  localparam int unsigned W = 32;
  localparam int unsigned LAT = W + 2;

  logic         Clk;
  logic         Clrn;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         wr_hi;
  logic         wr_lo;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic         dz;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int unsigned  cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc;
  int unsigned n_checks;
  int unsigned n_pass;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  ex_muldiv #(.WIDTH(W)) dut (
    .Clk   (Clk),
    .Clrn  (Clrn),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .wr_hi (wr_hi),
    .wr_lo (wr_lo),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .dz    (dz),
    .hi    (hi),
    .lo    (lo)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every done must match the oldest queued expectation.
  always @(negedge Clk) begin
    if (Clrn === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(done), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("hi", 64'(hi), 64'(e.hi));
        check("lo", 64'(lo), 64'(e.lo));
        check("dz", 64'(dz), 64'(e.dz));
        check("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Called at a negedge; leaves the bench at the negedge of cycle 1.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input bit push, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                       input logic edz);
    exp_t e;
    start = 1'b1;
    op    = o;
    a     = aa;
    b     = bb;
    if (push) begin
      e.hi  = ehi;
      e.lo  = elo;
      e.dz  = edz;
      e.cyc = cyc + LAT;
      sb.push_back(e);
    end
    @(negedge Clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge Clk);
      n++;
    end
    check("drain", 64'(sb.size()), 64'(0));
    sb.delete();
    @(negedge Clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    Clrn  = 1'b0;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    flush = 1'b0;
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    wdata = '0;
    #3;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_dz",   64'(dz),   64'(0));
    check("rst_hi",   64'(hi),   64'(0));
    check("rst_lo",   64'(lo),   64'(0));
    @(negedge Clk);
    @(negedge Clk);
    Clrn = 1'b1;
    @(negedge Clk);

    // MULTU max*max with busy profile over cycles 1..34.
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    for (int k = 1; k <= 34; k++) begin
      check($sformatf("busy_c%0d", k), 64'(busy), 64'(k <= 33));
      if (k < 34) @(negedge Clk);
    end
    drain();

    issue(MULT, 32'hFFFF_FFFD, 32'd7, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    drain();
    issue(DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    drain();
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h8000_0000, 1'b0);
    drain();
    issue(DIVU, 32'h1234, 32'h0, 1'b1, 32'h1234, 32'hFFFF_FFFF, 1'b1);
    drain();
    issue(DIV, 32'hFFFF_FFFB, 32'h0, 1'b1, 32'hFFFF_FFFB, 32'h0000_0001, 1'b1);
    drain();

    // Back-to-back: second start in the done cycle of the first.
    issue(MULTU, 32'd6, 32'd7, 1'b1, 32'h0, 32'd42, 1'b0);
    repeat (33) @(negedge Clk);
    issue(DIVU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0);
    drain();

    // Restart at cycle 10: only the second operation completes, at cycle 44.
    issue(MULTU, 32'd2, 32'd3, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (9) @(negedge Clk);
    issue(MULTU, 32'd4, 32'd5, 1'b1, 32'h0, 32'd20, 1'b0);
    drain();

    // Flushed start at cycle 20 of a run leaves it untouched.
    issue(MULTU, 32'd9, 32'd9, 1'b1, 32'h0, 32'd81, 1'b0);
    repeat (19) @(negedge Clk);
    start = 1'b1; flush = 1'b1; op = DIVU; a = 32'd1; b = 32'd1;
    @(negedge Clk);
    start = 1'b0; flush = 1'b0;
    drain();

    // Flushed start while idle: nothing happens.
    start = 1'b1; flush = 1'b1; op = MULTU; a = 32'd3; b = 32'd3;
    @(negedge Clk);
    start = 1'b0; flush = 1'b0;
    check("flush_idle_busy", 64'(busy), 64'(0));
    repeat (40) @(negedge Clk);
    check("flush_idle_lo", 64'(lo), 64'(81));

    // MTHI during RUN aborts the operation.
    issue(MULTU, 32'd3, 32'd3, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (4) @(negedge Clk);
    wr_hi = 1'b1; wdata = 32'hAA;
    @(negedge Clk);
    wr_hi = 1'b0;
    check("mt_busy", 64'(busy), 64'(0));
    check("mt_hi",   64'(hi),   64'(32'hAA));
    check("mt_lo",   64'(lo),   64'(81));
    repeat (40) @(negedge Clk);
    check("mt_hi_hold", 64'(hi), 64'(32'hAA));

    // MTLO together with an accepted start: start wins.
    wr_lo = 1'b1; wdata = 32'h55;
    issue(MULTU, 32'd5, 32'd5, 1'b1, 32'h0, 32'd25, 1'b0);
    wr_lo = 1'b0;
    check("mtlo_drop_lo",   64'(lo),   64'(81));
    check("mtlo_drop_busy", 64'(busy), 64'(1));
    drain();

    // Asynchronous reset at cycle 15 of a DIV.
    issue(DIV, 32'd100, 32'hFFFF_FFFD, 1'b1, 32'd1, 32'hFFFF_FFDF, 1'b0);
    repeat (14) @(negedge Clk);
    #3;
    Clrn = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_done", 64'(done), 64'(0));
    check("mid_rst_hi",   64'(hi),   64'(0));
    check("mid_rst_lo",   64'(lo),   64'(0));
    @(negedge Clk);
    @(negedge Clk);
    Clrn = 1'b1;
    @(negedge Clk);
    issue(MULTU, 32'd6, 32'd7, 1'b1, 32'h0, 32'd42, 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the decoded mul/div operation and the forwarded rs/rt operands latched in ID/EX. It computes a 2·WIDTH-bit product or a quotient/remainder pair at one bit per cycle and owns the architectural HI/LO registers. Its `busy` output feeds the hazard unit, which stalls MFHI/MFLO (and the ID/EX enable) while an operation is in flight.

## Interface
- `WIDTH`, 32, operand width; HI/LO are each `WIDTH` bits; iteration count = `WIDTH`.

- `Clk` in 1: single clock, rising edge.
- `Clrn` in 1: reset, asynchronous, active-low.
- `start` in 1: a valid mul/div instruction is in EX this cycle.
- `op` in 2: operation select.
  - 00 MULT (signed)
  - 01 MULTU
  - 10 DIV (signed)
  - 11 DIVU
- `a` in WIDTH: rs operand (dividend / multiplicand).
- `b` in WIDTH: rt operand (divisor / multiplier).
- `flush` in 1: EX instruction is cancelled (stall bubble or control dependence); gates `start`.
- `wr_hi` in 1: MTHI.
- `wr_lo` in 1: MTLO.
- `wdata` in WIDTH: data for MTHI/MTLO.
- `busy` out 1: operation in flight (RUN or FIX state).
- `done` out 1: one-cycle pulse; HI/LO hold the new result in that cycle.
- `dz` out 1: divide-by-zero flag; valid only while `done`=1.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- FSM states: IDLE, RUN, FIX. Counter is 6 bits, loaded with `WIDTH`.
- Accepted start = `start & ~flush`. It is accepted in any state; if an operation is already running, that operation is abandoned and restarted.
- On an accepted start (at the clock edge):
  - Latch `op`.
  - Record sign_a and sign_b; these are the operand MSBs for signed ops and 0 for unsigned ops.
  - Load the magnitudes |a| and |b|. Signed magnitudes use two's-complement negation, so 0x80000000 maps to 0x80000000 as unsigned.
  - Counter ← `WIDTH`; state → RUN.
- RUN, multiply: shift-add, one multiplier bit per cycle, into a 2·WIDTH-bit accumulator.
- RUN, divide: restoring division, one quotient bit per cycle. Shift the partial remainder left by one, trial-subtract the divisor, and set the quotient bit if the result is non-negative.
- RUN: counter decrements each cycle; when it reaches 1, state → FIX.
- FIX, multiply: if sign_a ^ sign_b, negate the 2·WIDTH-bit product. HI ← upper half, LO ← lower half.
- FIX, divide:
  - If sign_a ^ sign_b, negate the quotient.
  - If sign_a, negate the remainder.
  - LO ← quotient, HI ← remainder.
- FIX always: `done` ← 1 (registered), `dz` ← (divide & b==0); state → IDLE.
- Divide by zero: no special path. The natural restoring result applies, giving HI = a, and LO = 0xFFFFFFFF for DIVU, or for DIV with a ≥ 0. For DIV with a < 0, LO = 0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0, `dz` = 0.
- `wr_hi` / `wr_lo`:
  - Write `wdata` at the edge.
  - If asserted while `busy`, the in-flight operation is aborted (state → IDLE, no `done`), and the MT value is written.
  - If asserted in the same cycle as an accepted start, the start wins and the MT write is dropped.
- HI/LO change only on a FIX edge, an MT write, or reset.

## Timing
- Reset (`Clrn`=0, asynchronous): state IDLE, counter 0, `busy`=0, `done`=0, `dz`=0, `hi`=0, `lo`=0, and all datapath registers 0. This applies at any point mid-operation; there is no partial HI/LO update.
- Cycle numbering: start is accepted at edge E0.
  - RUN occupies cycles 1..WIDTH.
  - FIX is cycle WIDTH+1.
  - `done`=1 and new HI/LO are visible in cycle WIDTH+2, which is cycle 34 for WIDTH=32.
- `busy` is registered: 1 in cycles 1..WIDTH+1, and 0 in the `done` cycle.
- `done` lasts exactly one cycle. Back-to-back: a start accepted in the `done` cycle gives its next `done` exactly WIDTH+2 cycles later.
- `start` asserted while `flush`=1 has no effect in any state and does not disturb a running operation.
- `busy` never depends combinationally on inputs.

## Test plan
- Unsigned multiply: MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → cycle 34: `done`=1, HI=0xFFFFFFFE, LO=0x00000001. `busy`=1 in cycles 1–33 and 0 in cycle 34.
- Signed multiply and divide:
  - MULT −3 × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
  - DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero:
  - DIVU 0x1234 / 0 → HI=0x1234, LO=0xFFFFFFFF, `dz`=1 during `done`.
  - DIV −5 / 0 → HI=0xFFFFFFFB, LO=0x00000001.
- Restart and flush:
  - Start MULTU 2×3; at cycle 10, start MULTU 4×5 → exactly one `done`, at cycle 44, with LO=20.
  - `start`+`flush` at cycle 20 of a run → no effect.
- MT interaction:
  - `wr_hi` with wdata=0xAA during RUN → next cycle `busy`=0, HI=0xAA, LO unchanged, no `done`.
  - `wr_lo` and an accepted start in the same cycle → start proceeds, LO is not written.
- Reset mid-operation: assert `Clrn`=0 asynchronously at cycle 15 of a DIV → immediately `busy`=0, HI=LO=0, `done`=0. After release, a new MULTU 6×7 completes with LO=42 at cycle 34.
